uv_exposure_sequencer: RTL and testbench

Sequences one UV exposure run: latches and clamps the user settings, then alternates ON/OFF phases for a programmed number of repetitions on a 1 ms time base. It drives the LED gate output and issues intensity writes to the I2C digipot controller through a single-entry write queue. It sits between the button/encoder front-end and `i2c_controller`, replacing the inline fire logic in the top level.

---
 rtl/uven_pkg.sv | 23 ++
 rtl/ms_tick_gen.sv | 32 +++
 rtl/uv_exposure_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_uv_exposure_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uven_pkg.sv
// Shared types and constants for the UV exposure sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uven_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_ON    = 3'd2,
    ST_OFF   = 3'd3,
    ST_SAFE  = 3'd4
  } uven_state_e;

  localparam int unsigned TIME_MAX     = 9999;
  localparam int unsigned INT_MAX      = 100;
  localparam logic [6:0]  DIGIPOT_ADDR = 7'h2F;

  // Saturating clamp for the 14-bit time/repetition fields.
  function automatic logic [13:0] clamp14(input logic [13:0] v, input logic [13:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a 1 ms tick.
// Latency: tick_o is high during the TICK_DIV-th cycle after a restart.
// Backpressure: none; restart_i zeroes the count so the next ms is full length.
// Ports: clk_i/rst_ni clock and async active-low reset, restart_i sync restart,
//        tick_o single-cycle tick.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 16000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] WRAP = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == WRAP);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || cnt_q == WRAP) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uv_exposure_sequencer.sv
// UV exposure run sequencer: latches/clamps settings, alternates ON/OFF phases
// on a 1 ms base, drives the LED gate and queues digipot writes to the I2C block.
// Latency: all outputs registered; uv_on rises 1 cycle after fire is sampled.
// Backpressure: single-entry write queue held until i2c_ready, newest value wins.
// Ports: CLK/reset_n clock + async active-low reset; arm/fire/abort controls;
//        on_time_ms/off_time_ms/repetitions/intensity settings; i2c_ready in,
//        i2c_enable/i2c_data write request out; uv_on gate; state/elapsed_ms/
//        rep_count/done status; fault watchdog trip.
// Optional: UVEN_WATCHDOG_EN adds a cumulative ON-time limit (MAX_ON_MS).
module uv_exposure_sequencer #(
  parameter int unsigned TICK_DIV  = 16000,
  parameter int unsigned TIME_MAX  = 9999,
  parameter int unsigned INT_MAX   = 100
`ifdef UVEN_WATCHDOG_EN
  , parameter int unsigned MAX_ON_MS = 600000
`endif
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        arm,
  input  logic        fire,
  input  logic        abort,
  input  logic [13:0] on_time_ms,
  input  logic [13:0] off_time_ms,
  input  logic [13:0] repetitions,
  input  logic [7:0]  intensity,
  input  logic        i2c_ready,
  output logic        i2c_enable,
  output logic [7:0]  i2c_data,
  output logic        uv_on,
  output logic [2:0]  state,
  output logic [13:0] elapsed_ms,
  output logic [13:0] rep_count,
  output logic        done,
  output logic        fault
);

  import uven_pkg::*;

  localparam logic [13:0] TMAX = 14'(TIME_MAX);
  localparam logic [7:0]  IMAX = 8'(INT_MAX);

  uven_state_e state_q, state_d;
  logic [13:0] on_q, on_d, off_q, off_d, reps_q, reps_d;
  logic [7:0]  int_q, int_d;
  logic [13:0] elapsed_q, elapsed_d, rep_q, rep_d, phase_ms, rep_nxt;
  logic        done_q, done_d, uv_on_q;
  logic        pend_q, pend_d, en_q, en_d, issue;
  logic [7:0]  wdat_q, wdat_d, data_q, data_d;
  logic        push, restart, tick, wd_trip, fault_q;
  logic [7:0]  push_val;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i     (CLK),
    .rst_ni    (reset_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

`ifdef UVEN_WATCHDOG_EN
  localparam int unsigned OW = $clog2(MAX_ON_MS + 1);
  logic [OW-1:0] onms_q, onms_d, onms_nxt;
  logic          fault_d;

  // Cumulative ON time only accrues in ON; it is held at zero while idle so a
  // new arm starts from a clean budget.
  always_comb begin
    onms_nxt = onms_q + OW'(tick);
    onms_d   = onms_q;
    fault_d  = fault_q;
    wd_trip  = 1'b0;
    if (state_q == ST_IDLE) begin
      onms_d = '0;
      if (!arm) fault_d = 1'b0;
    end else if (state_q == ST_ON) begin
      onms_d = onms_nxt;
      if (onms_nxt >= OW'(MAX_ON_MS)) begin
        wd_trip = 1'b1;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      onms_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      onms_q  <= onms_d;
      fault_q <= fault_d;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign fault_q = 1'b0;
`endif

  // Elapsed count as it will read after this edge; comparing it (rather than
  // elapsed_q) makes a phase last exactly N ticks and a zero-length phase
  // exit on the cycle after entry.
  assign phase_ms = elapsed_q + 14'(tick);
  assign rep_nxt  = rep_q + 14'd1;

  always_comb begin
    state_d   = state_q;
    on_d      = on_q;
    off_d     = off_q;
    reps_d    = reps_q;
    int_d     = int_q;
    elapsed_d = elapsed_q;
    rep_d     = rep_q;
    done_d    = 1'b0;
    restart   = 1'b0;
    push      = 1'b0;
    push_val  = 8'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm && !fault_q) begin
          state_d  = ST_ARMED;
          on_d     = clamp14(on_time_ms, TMAX);
          off_d    = clamp14(off_time_ms, TMAX);
          reps_d   = (repetitions == 14'd0) ? 14'd1 : clamp14(repetitions, TMAX);
          int_d    = (intensity > IMAX) ? IMAX : intensity;
          push     = 1'b1;
          push_val = int_d;
        end
      end
      ST_ARMED: begin
        if (!arm || abort) begin
          state_d = ST_SAFE;
          push    = 1'b1;
        end else if (fire) begin
          state_d   = ST_ON;
          rep_d     = 14'd0;
          elapsed_d = 14'd0;
          restart   = 1'b1;
          push      = 1'b1;
          push_val  = int_q;
        end
      end
      ST_ON: begin
        if (!arm || abort || wd_trip) begin
          state_d   = ST_SAFE;
          elapsed_d = 14'd0;
          push      = 1'b1;
        end else if (phase_ms == on_q) begin
          state_d   = ST_OFF;
          elapsed_d = 14'd0;
          restart   = 1'b1;
          push      = 1'b1;
        end else begin
          elapsed_d = phase_ms;
        end
      end
      ST_OFF: begin
        if (!arm || abort) begin
          state_d   = ST_SAFE;
          elapsed_d = 14'd0;
          push      = 1'b1;
        end else if (phase_ms == off_q) begin
          rep_d     = rep_nxt;
          elapsed_d = 14'd0;
          if (rep_nxt == reps_q) begin
            state_d = ST_ARMED;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_ON;
            restart  = 1'b1;
            push     = 1'b1;
            push_val = int_q;
          end
        end else begin
          elapsed_d = phase_ms;
        end
      end
      ST_SAFE: begin
        // Leave only once the zero write has actually gone out.
        if (!pend_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write queue: a push in the same cycle as an issue becomes the new pending
  // entry; the en_q term keeps requests at least one idle cycle apart.
  always_comb begin
    issue  = pend_q && i2c_ready && !en_q;
    pend_d = pend_q;
    wdat_d = wdat_q;
    if (issue) pend_d = 1'b0;
    if (push) begin
      pend_d = 1'b1;
      wdat_d = push_val;
    end
    en_d   = issue;
    data_d = issue ? wdat_q : 8'd0;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      on_q      <= '0;
      off_q     <= '0;
      reps_q    <= '0;
      int_q     <= '0;
      elapsed_q <= '0;
      rep_q     <= '0;
      done_q    <= 1'b0;
      uv_on_q   <= 1'b0;
      pend_q    <= 1'b0;
      wdat_q    <= '0;
      en_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      on_q      <= on_d;
      off_q     <= off_d;
      reps_q    <= reps_d;
      int_q     <= int_d;
      elapsed_q <= elapsed_d;
      rep_q     <= rep_d;
      done_q    <= done_d;
      uv_on_q   <= (state_d == ST_ON);
      pend_q    <= pend_d;
      wdat_q    <= wdat_d;
      en_q      <= en_d;
      data_q    <= data_d;
    end
  end

  assign i2c_enable = en_q;
  assign i2c_data   = data_q;
  assign uv_on      = uv_on_q;
  assign state      = state_q;
  assign elapsed_ms = elapsed_q;
  assign rep_count  = rep_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_uv_exposure_sequencer.sv
// Directed bench for uv_exposure_sequencer with TICK_DIV=4; digipot writes are
// checked against an expected-write queue filled when stimulus is driven.
module tb_uv_exposure_sequencer;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0, fire = 1'b0, abort = 1'b0, i2c_ready = 1'b1;
  logic [13:0] on_time_ms = '0, off_time_ms = '0, repetitions = '0;
  logic [7:0]  intensity = '0;
  logic        i2c_enable, uv_on, done, fault;
  logic [7:0]  i2c_data;
  logic [2:0]  state;
  logic [13:0] elapsed_ms, rep_count;

`ifdef UVEN_WATCHDOG_EN
  uv_exposure_sequencer #(.TICK_DIV(4), .MAX_ON_MS(5)) dut (
`else
  uv_exposure_sequencer #(.TICK_DIV(4)) dut (
`endif
    .CLK(CLK), .reset_n(reset_n), .arm(arm), .fire(fire), .abort(abort),
    .on_time_ms(on_time_ms), .off_time_ms(off_time_ms), .repetitions(repetitions),
    .intensity(intensity), .i2c_ready(i2c_ready), .i2c_enable(i2c_enable),
    .i2c_data(i2c_data), .uv_on(uv_on), .state(state), .elapsed_ms(elapsed_ms),
    .rep_count(rep_count), .done(done), .fault(fault)
  );

  always #5 CLK = ~CLK;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_ON = 3'd2, S_OFF = 3'd3, S_SAFE = 3'd4;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int n_wr = 0;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Write monitor: every request must match the oldest expected write.
  always @(negedge CLK) begin
    if (reset_n === 1'b1) begin
      if (i2c_enable === 1'b1) begin
        n_wr++;
        if (exp_q.size() == 0) chk("wr_unexpected_qsize", 32'(exp_q.size()), 32'd1);
        else                   chk("wr_data", 32'(i2c_data), 32'(exp_q.pop_front()));
        chk("wr_back_to_back", 32'(prev_en), 32'd0);
      end
      prev_en = i2c_enable;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_fire;
    fire = 1'b1;
    @(negedge CLK);
    fire = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
    int n = 0;
    while (state !== s && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  // Counts cycles while uv_on holds lvl, stopping early on done.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (uv_on === lvl && done !== 1'b1 && n < 60000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic set_cfg(input int on, input int off, input int reps, input int inten);
    on_time_ms  = 14'(on);
    off_time_ms = 14'(off);
    repetitions = 14'(reps);
    intensity   = 8'(inten);
  endtask

  initial begin
    int n;
    logic seen_on;
    cyc(3);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_uv_on", 32'(uv_on), 32'd0);
    chk("rst_i2c_enable", 32'(i2c_enable), 32'd0);
    chk("rst_i2c_data", 32'(i2c_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rep_count", 32'(rep_count), 32'd0);
    chk("rst_elapsed", 32'(elapsed_ms), 32'd0);
    reset_n = 1'b1;
    cyc(2);

`ifdef UVEN_WATCHDOG_EN
    // Watchdog: 5 ms budget runs out 2 ms into the second ON phase.
    set_cfg(3, 2, 3, 70);
    arm = 1'b1;
    exp_q.push_back(8'd70);
    cyc(1);
    chk("wd_armed", 32'(state), 32'(S_ARMED));
    cyc(4);
    exp_q.push_back(8'd70); exp_q.push_back(8'd0);
    exp_q.push_back(8'd70); exp_q.push_back(8'd0);
    pulse_fire;
    run_len(1'b1, n); chk("wd_on1_len", 32'(n), 32'd12);
    run_len(1'b0, n); chk("wd_off1_len", 32'(n), 32'd8);
    run_len(1'b1, n); chk("wd_on2_len", 32'(n), 32'd8);
    chk("wd_state_safe", 32'(state), 32'(S_SAFE));
    chk("wd_fault_set", 32'(fault), 32'd1);
    wait_state(S_IDLE, 20, "wd_to_idle");
    cyc(4);
    chk("wd_rearm_blocked", 32'(state), 32'(S_IDLE));
    chk("wd_fault_sticky", 32'(fault), 32'd1);
    arm = 1'b0;
    cyc(2);
    chk("wd_fault_cleared", 32'(fault), 32'd0);
    chk("wd_sb_drain", 32'(exp_q.size()), 32'd0);
`else
    // Basic run: 3 ms on, 2 ms off, two repetitions at intensity 70.
    set_cfg(3, 2, 2, 70);
    arm = 1'b1;
    exp_q.push_back(8'd70);
    cyc(1);
    chk("basic_armed", 32'(state), 32'(S_ARMED));
    cyc(4);
    exp_q.push_back(8'd70); exp_q.push_back(8'd0);
    exp_q.push_back(8'd70); exp_q.push_back(8'd0);
    pulse_fire;
    chk("basic_uv_rise", 32'(uv_on), 32'd1);
    chk("basic_state_on", 32'(state), 32'(S_ON));
    run_len(1'b1, n); chk("basic_on1_len", 32'(n), 32'd12);
    chk("basic_state_off", 32'(state), 32'(S_OFF));
    run_len(1'b0, n); chk("basic_off1_len", 32'(n), 32'd8);
    run_len(1'b1, n); chk("basic_on2_len", 32'(n), 32'd12);
    run_len(1'b0, n); chk("basic_off2_len", 32'(n), 32'd8);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_done_state", 32'(state), 32'(S_ARMED));
    chk("basic_rep_count", 32'(rep_count), 32'd2);
    cyc(1);
    chk("basic_done_pulse", 32'(done), 32'd0);
    cyc(3);
    chk("basic_sb_drain", 32'(exp_q.size()), 32'd0);

    // Abort mid-ON once elapsed_ms reads 1.
    exp_q.push_back(8'd70);
    pulse_fire;
    n = 0;
    while (elapsed_ms !== 14'd1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_elapsed", 32'(elapsed_ms), 32'd1);
    exp_q.push_back(8'd0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_uv_off", 32'(uv_on), 32'd0);
    chk("abort_state_safe", 32'(state), 32'(S_SAFE));
    arm = 1'b0;
    wait_state(S_IDLE, 20, "abort_to_idle");
    cyc(3);
    chk("abort_sb_drain", 32'(exp_q.size()), 32'd0);

    // Busy I2C across ON->OFF: queued 70s are overwritten, only 0 is sent.
    i2c_ready = 1'b0;
    set_cfg(1, 1, 1, 70);
    arm = 1'b1;
    cyc(1);
    chk("busy_armed", 32'(state), 32'(S_ARMED));
    cyc(2);
    pulse_fire;
    wait_state(S_OFF, 20, "busy_off");
    n_wr = 0;
    exp_q.push_back(8'd0);
    i2c_ready = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("busy_done", 32'(done), 32'd1);
    cyc(3);
    chk("busy_write_count", 32'(n_wr), 32'd1);
    chk("busy_sb_drain", 32'(exp_q.size()), 32'd0);

    // Disarm and fire in the same cycle while ARMED: disarm wins.
    exp_q.push_back(8'd0);
    arm = 1'b0;
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    chk("disarm_state_safe", 32'(state), 32'(S_SAFE));
    seen_on = uv_on;
    n = 0;
    while (state !== S_IDLE && n < 20) begin
      @(negedge CLK);
      seen_on = seen_on | uv_on;
      n++;
    end
    chk("disarm_to_idle", 32'(state), 32'(S_IDLE));
    chk("disarm_uv_never", 32'(seen_on), 32'd0);
    cyc(3);
    chk("disarm_sb_drain", 32'(exp_q.size()), 32'd0);

    // Clamping; inputs changed after arming must not affect the run.
    set_cfg(12000, 1, 0, 200);
    arm = 1'b1;
    exp_q.push_back(8'd100);
    cyc(1);
    set_cfg(1, 5, 5, 5);
    cyc(4);
    exp_q.push_back(8'd100); exp_q.push_back(8'd0);
    pulse_fire;
    run_len(1'b1, n); chk("clamp_on_len", 32'(n), 32'd39996);
    run_len(1'b0, n); chk("clamp_off_len", 32'(n), 32'd4);
    chk("clamp_done", 32'(done), 32'd1);
    chk("clamp_rep_count", 32'(rep_count), 32'd1);
    chk("clamp_state", 32'(state), 32'(S_ARMED));
    cyc(3);
    chk("clamp_sb_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-run with a write still pending: gate drops, write discarded.
    i2c_ready = 1'b0;
    pulse_fire;
    cyc(2);
    chk("rstrun_uv_on", 32'(uv_on), 32'd1);
    arm = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstrun_uv_off", 32'(uv_on), 32'd0);
    chk("rstrun_state", 32'(state), 32'(S_IDLE));
    cyc(1);
    reset_n = 1'b1;
    i2c_ready = 1'b1;
    n_wr = 0;
    cyc(6);
    chk("rstrun_no_write", 32'(n_wr), 32'd0);
    chk("rstrun_idle", 32'(state), 32'(S_IDLE));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
